// File: rtl/backward_propagation.sv
// SGD parameter update for the 2-2-1 XOR network: sigmoid/cross-entropy output delta,
// ReLU hidden deltas, gradients and learning-rate-shifted updates, all in signed Q8.8.
module backward_propagation #(
  parameter int LR_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fp_valid,
  input  logic signed [15:0] x1,
  input  logic signed [15:0] x2,
  input  logic signed [15:0] target,
  input  logic signed [15:0] h1,
  input  logic signed [15:0] h2,
  input  logic signed [15:0] y,
  input  logic signed [15:0] w11_in,
  input  logic signed [15:0] w12_in,
  input  logic signed [15:0] w21_in,
  input  logic signed [15:0] w22_in,
  input  logic signed [15:0] w31_in,
  input  logic signed [15:0] w32_in,
  input  logic signed [15:0] b1_in,
  input  logic signed [15:0] b2_in,
  input  logic signed [15:0] b3_in,
  output logic signed [15:0] w11_new,
  output logic signed [15:0] w12_new,
  output logic signed [15:0] w21_new,
  output logic signed [15:0] w22_new,
  output logic signed [15:0] w31_new,
  output logic signed [15:0] w32_new,
  output logic signed [15:0] b1_new,
  output logic signed [15:0] b2_new,
  output logic signed [15:0] b3_new,
  output logic signed [15:0] err,
  output logic               busy,
  output logic               bp_valid
);

  typedef enum logic [2:0] {IDLE, DELTA_OUT, DELTA_HID, GRAD, UPDATE} state_t;

  state_t state;
  logic   fp_q;
  logic signed [15:0] x1_r, x2_r, tg_r, h1_r, h2_r, y_r;
  logic signed [15:0] w11_r, w12_r, w21_r, w22_r, w31_r, w32_r, b1_r, b2_r, b3_r;
  logic signed [15:0] d1, d2, d3;
  logic signed [23:0] g11, g12, g21, g22, g31, g32;

  function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
    if (v > 26'sd32767)       return 16'sh7fff;
    else if (v < -26'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // 26-bit subtraction leaves headroom for a full 24-bit gradient against a 16-bit parameter
  function automatic logic signed [15:0] upd(input logic signed [15:0] p,
                                             input logic signed [23:0] g);
    logic signed [25:0] s;
    s = 26'(p) - 26'(g >>> LR_SHIFT);
    return sat16(s);
  endfunction

  logic signed [16:0] diff;
  logic signed [31:0] pd1, pd2, p11, p12, p21, p22, p31, p32;
  logic               start;

  assign diff  = 17'(y_r) - 17'(tg_r);
  assign pd1   = 32'(w31_r) * 32'(d3);
  assign pd2   = 32'(w32_r) * 32'(d3);
  assign p31   = 32'(d3) * 32'(h1_r);
  assign p32   = 32'(d3) * 32'(h2_r);
  assign p11   = 32'(d1) * 32'(x1_r);
  assign p12   = 32'(d1) * 32'(x2_r);
  assign p21   = 32'(d2) * 32'(x1_r);
  assign p22   = 32'(d2) * 32'(x2_r);
  // busy is still high on the cycle UPDATE returns to IDLE, which enforces the 6-clock spacing
  assign start = fp_valid & ~fp_q & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fp_q <= 1'b0;
      busy <= 1'b0;
      bp_valid <= 1'b0;
      {x1_r, x2_r, tg_r, h1_r, h2_r, y_r} <= '0;
      {w11_r, w12_r, w21_r, w22_r, w31_r, w32_r, b1_r, b2_r, b3_r} <= '0;
      {d1, d2, d3} <= '0;
      {g11, g12, g21, g22, g31, g32} <= '0;
      {w11_new, w12_new, w21_new, w22_new, w31_new, w32_new} <= '0;
      {b1_new, b2_new, b3_new, err} <= '0;
    end else begin
      fp_q <= fp_valid;
      case (state)
        IDLE: begin
          bp_valid <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            x1_r <= x1; x2_r <= x2; tg_r <= target;
            h1_r <= h1; h2_r <= h2; y_r <= y;
            w11_r <= w11_in; w12_r <= w12_in; w21_r <= w21_in;
            w22_r <= w22_in; w31_r <= w31_in; w32_r <= w32_in;
            b1_r <= b1_in; b2_r <= b2_in; b3_r <= b3_in;
            busy <= 1'b1;
            state <= DELTA_OUT;
          end
        end
        DELTA_OUT: begin
          d3 <= sat16(26'(diff));
          state <= DELTA_HID;
        end
        DELTA_HID: begin
          d1 <= (h1_r > 0) ? sat16(26'(pd1 >>> 8)) : '0;
          d2 <= (h2_r > 0) ? sat16(26'(pd2 >>> 8)) : '0;
          state <= GRAD;
        end
        GRAD: begin
          g31 <= 24'(p31 >>> 8);
          g32 <= 24'(p32 >>> 8);
          g11 <= 24'(p11 >>> 8);
          g12 <= 24'(p12 >>> 8);
          g21 <= 24'(p21 >>> 8);
          g22 <= 24'(p22 >>> 8);
          state <= UPDATE;
        end
        UPDATE: begin
          w11_new <= upd(w11_r, g11);
          w12_new <= upd(w12_r, g12);
          w21_new <= upd(w21_r, g21);
          w22_new <= upd(w22_r, g22);
          w31_new <= upd(w31_r, g31);
          w32_new <= upd(w32_r, g32);
          b1_new <= upd(b1_r, 24'(d1));
          b2_new <= upd(b2_r, 24'(d2));
          b3_new <= upd(b3_r, 24'(d3));
          err <= d3;
          bp_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backward_propagation.sv
// Self-checking bench for backward_propagation: vector table plus scoreboard, with
// reset-abort, level-hold, overlap and back-to-back sequences.
module tb_backward_propagation;

  typedef struct {
    logic signed [15:0] err;
    logic signed [15:0] w[6];
    logic signed [15:0] b[3];
  } exp_t;

  typedef struct {
    logic signed [15:0] x1, x2, tg, h1, h2, y;
    logic signed [15:0] w[6];
    logic signed [15:0] b[3];
    exp_t e;
  } vec_t;

  logic clk = 0, rst_n = 0, fp_valid = 0;
  logic signed [15:0] x1, x2, target, h1, h2, y;
  logic signed [15:0] w11_in, w12_in, w21_in, w22_in, w31_in, w32_in, b1_in, b2_in, b3_in;
  logic signed [15:0] w11_new, w12_new, w21_new, w22_new, w31_new, w32_new;
  logic signed [15:0] b1_new, b2_new, b3_new, err;
  logic busy, bp_valid;

  int errors = 0, checks = 0, pulses = 0;
  exp_t sb[$];

  backward_propagation #(.LR_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .fp_valid(fp_valid),
    .x1(x1), .x2(x2), .target(target), .h1(h1), .h2(h2), .y(y),
    .w11_in(w11_in), .w12_in(w12_in), .w21_in(w21_in), .w22_in(w22_in),
    .w31_in(w31_in), .w32_in(w32_in), .b1_in(b1_in), .b2_in(b2_in), .b3_in(b3_in),
    .w11_new(w11_new), .w12_new(w12_new), .w21_new(w21_new), .w22_new(w22_new),
    .w31_new(w31_new), .w32_new(w32_new), .b1_new(b1_new), .b2_new(b2_new),
    .b3_new(b3_new), .err(err), .busy(busy), .bp_valid(bp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference model written directly from the update equations, learning rate 1/4
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int d1, d2, d3, g[6];
    d3 = sat16(int'(v.y) - int'(v.tg));
    d1 = (v.h1 > 0) ? sat16((int'(v.w[4]) * d3) >>> 8) : 0;
    d2 = (v.h2 > 0) ? sat16((int'(v.w[5]) * d3) >>> 8) : 0;
    g[0] = (d1 * int'(v.x1)) >>> 8;
    g[1] = (d1 * int'(v.x2)) >>> 8;
    g[2] = (d2 * int'(v.x1)) >>> 8;
    g[3] = (d2 * int'(v.x2)) >>> 8;
    g[4] = (d3 * int'(v.h1)) >>> 8;
    g[5] = (d3 * int'(v.h2)) >>> 8;
    for (int i = 0; i < 6; i++) e.w[i] = 16'(sat16(int'(v.w[i]) - (g[i] >>> 2)));
    e.b[0] = 16'(sat16(int'(v.b[0]) - (d1 >>> 2)));
    e.b[1] = 16'(sat16(int'(v.b[1]) - (d2 >>> 2)));
    e.b[2] = 16'(sat16(int'(v.b[2]) - (d3 >>> 2)));
    e.err = 16'(d3);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bp_valid) begin
      logic signed [15:0] aw[6];
      logic signed [15:0] ab[3];
      exp_t e;
      pulses++;
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_pulse: got bp_valid=1 expected no pulse");
      end else begin
        e = sb.pop_front();
        aw = '{w11_new, w12_new, w21_new, w22_new, w31_new, w32_new};
        ab = '{b1_new, b2_new, b3_new};
        chk("err", err, e.err);
        for (int i = 0; i < 6; i++) chk($sformatf("w_new[%0d]", i), aw[i], e.w[i]);
        for (int i = 0; i < 3; i++) chk($sformatf("b%0d_new", i + 1), ab[i], e.b[i]);
      end
    end
  end

  task automatic drive(input vec_t v);
    x1 = v.x1; x2 = v.x2; target = v.tg; h1 = v.h1; h2 = v.h2; y = v.y;
    {w11_in, w12_in, w21_in, w22_in, w31_in, w32_in} = {v.w[0], v.w[1], v.w[2], v.w[3], v.w[4], v.w[5]};
    {b1_in, b2_in, b3_in} = {v.b[0], v.b[1], v.b[2]};
  endtask

  task automatic scramble();
    x1 = 16'h1234; x2 = -16'sd999; target = 16'h7777; h1 = 16'h0400; h2 = 16'h0500; y = -16'sd3000;
    {w11_in, w12_in, w21_in, w22_in, w31_in, w32_in} = {6{16'h0abc}};
    {b1_in, b2_in, b3_in} = {3{16'h0def}};
  endtask

  // Full transaction: start, change inputs after capture, check latency and pulse shape
  task automatic run(input vec_t v, input string name);
    int k;
    @(negedge clk);
    drive(v);
    fp_valid = 1;
    sb.push_back(v.e);
    @(posedge clk);
    @(negedge clk);
    fp_valid = 0;
    scramble();
    chk({name, "_busy"}, busy, 1);
    k = 1;
    while (!bp_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, k, 5);
    @(negedge clk);
    chk({name, "_pulse_end"}, {busy, bp_valid}, 0);
  endtask

  vec_t vecs[7];
  vec_t v, v2;
  int p0;

  initial begin
    vecs[0].x1 = 256; vecs[0].x2 = 0; vecs[0].tg = 256; vecs[0].h1 = 256; vecs[0].h2 = 0; vecs[0].y = 128;
    vecs[0].w = '{256, 256, 256, 256, 256, 256}; vecs[0].b = '{0, 0, 0};
    vecs[0].e.err = -128; vecs[0].e.w = '{288, 256, 256, 256, 288, 256}; vecs[0].e.b = '{32, 0, 32};
    vecs[1] = vecs[0];
    vecs[1].h1 = 0; vecs[1].h2 = 0;
    vecs[1].e.err = -128; vecs[1].e.w = '{256, 256, 256, 256, 256, 256}; vecs[1].e.b = '{0, 0, 32};
    vecs[2] = vecs[0];
    vecs[2].w[4] = 32767; vecs[2].h1 = 32767; vecs[2].y = 0;
    vecs[2].e.err = -256; vecs[2].e.w = '{8448, 256, 256, 256, 32767, 256}; vecs[2].e.b = '{8192, 0, 64};
    for (int i = 3; i < 7; i++) begin
      vecs[i].x1 = 16'($urandom_range(0, 1023)) - 16'd512;
      vecs[i].x2 = 16'($urandom_range(0, 1023)) - 16'd512;
      vecs[i].h1 = 16'($urandom_range(0, 1023)) - 16'd256;
      vecs[i].h2 = 16'($urandom_range(0, 1023)) - 16'd256;
      vecs[i].y  = 16'($urandom_range(0, 256));
      vecs[i].tg = (i % 2) ? 16'sd256 : 16'sd0;
      for (int j = 0; j < 6; j++) vecs[i].w[j] = 16'($urandom_range(0, 2047)) - 16'd1024;
      for (int j = 0; j < 3; j++) vecs[i].b[j] = 16'($urandom_range(0, 511)) - 16'd256;
      vecs[i].e = model(vecs[i]);
    end

    scramble();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {w11_new, w31_new, b3_new, err, busy, bp_valid}, 0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Reset after E2 aborts the update with no pulse
    p0 = pulses;
    @(negedge clk);
    drive(vecs[6]); fp_valid = 1;
    @(posedge clk);
    @(negedge clk); fp_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk("abort_outputs", (w11_new | w12_new | w21_new | w22_new | w31_new | w32_new |
                             b1_new | b2_new | b3_new | err) != 0 || busy || bp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    chk("abort_no_pulse", pulses - p0, 0);
    run(vecs[0], "after_reset");

    // fp_valid held high for 20 cycles
    p0 = pulses;
    drive(vecs[2]); fp_valid = 1;
    sb.push_back(vecs[2].e);
    repeat (20) @(negedge clk);
    fp_valid = 0;
    repeat (4) @(negedge clk);
    chk("level_pulses", pulses - p0, 1);

    // Second rising edge sampled at E2 is dropped
    p0 = pulses;
    drive(vecs[3]); fp_valid = 1;
    sb.push_back(vecs[3].e);
    @(posedge clk);
    @(negedge clk); fp_valid = 0;
    @(negedge clk); fp_valid = 1;
    @(negedge clk); fp_valid = 0;
    repeat (10) @(negedge clk);
    chk("overlap_pulses", pulses - p0, 1);

    // Back-to-back starts 7 clocks apart, targets 256 then 0
    p0 = pulses;
    v = vecs[0];
    v2 = vecs[0]; v2.tg = 0; v2.e = model(v2);
    drive(v); fp_valid = 1;
    sb.push_back(v.e);
    @(posedge clk);
    @(negedge clk); fp_valid = 0;
    repeat (6) @(negedge clk);
    drive(v2); fp_valid = 1;
    sb.push_back(v2.e);
    @(posedge clk);
    @(negedge clk); fp_valid = 0;
    repeat (10) @(negedge clk);
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_err_last", err, 128);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
